// File: rtl/stack_io_host_if.sv
// rtl/stack_io_host_if.sv - byte-wide host bus between a host master and the stack I/O bridge
interface stack_io_host_if;
    logic       host_valid;
    logic       host_ready;
    logic       host_wr;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic [7:0] host_rdata;
    logic       host_rvalid;

    modport master (
        output host_valid, host_wr, host_addr, host_wdata,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  host_valid, host_wr, host_addr, host_wdata,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/stack_io_host.sv
// rtl/stack_io_host.sv - host I/O bridge: atomic input words, snapshot readback, halt detect
module stack_io_host #(
    parameter int          HALT_CYCLES = 1024,
    parameter int          HALT_W      = 11,
    parameter logic        RESET_HOLD  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    stack_io_host_if.slave        host,
    output logic [15:0]           o_getin,
    output logic [15:0]           o_getin2,
    output logic                  o_proc_reset,
    input  logic [15:0]           i_top_of_stack,
    input  logic [15:0]           i_second_of_stack,
    input  logic [31:0]           i_inst_count,
    output logic                  o_halted
);
    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_ready;
    logic                w_accept;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [7:0]          w_rd_data;
    logic [7:0]          r_rdata;
    logic [7:0]          r_stage_lo;
    logic [7:0]          r_stage2_lo;
    logic [15:0]         r_snap_tos;
    logic [15:0]         r_snap_sos;
    logic [31:0]         r_snap_cnt;
    logic [31:0]         r_prev_cnt;
    logic [HALT_W-1:0]   r_halt_cnt;
    logic                w_clear_halt;
    logic                w_stalled;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (host.host_valid && !host.host_wr) w_next = S_RESP;
            end
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept          = host.host_valid & w_ready;
    assign w_wr_acc          = w_accept & host.host_wr;
    assign w_rd_acc          = w_accept & ~host.host_wr;
    assign host.host_ready   = w_ready;
    assign host.host_rvalid  = (r_state == S_RESP);
    assign host.host_rdata   = r_rdata;

    // Address 0 returns the live TOS byte because it is the byte being latched this cycle.
    always_comb begin
        w_rd_data = 8'h00;
        case (host.host_addr)
            4'd0: w_rd_data = i_top_of_stack[7:0];
            4'd1: w_rd_data = r_snap_tos[15:8];
            4'd2: w_rd_data = r_snap_sos[7:0];
            4'd3: w_rd_data = r_snap_sos[15:8];
            4'd4: w_rd_data = r_snap_cnt[7:0];
            4'd5: w_rd_data = r_snap_cnt[15:8];
            4'd6: w_rd_data = r_snap_cnt[23:16];
            4'd7: w_rd_data = r_snap_cnt[31:24];
            4'd8: w_rd_data = {6'b0, o_halted, o_proc_reset};
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata    <= 8'h00;
            r_snap_tos <= 16'h0000;
            r_snap_sos <= 16'h0000;
            r_snap_cnt <= 32'h0;
        end else if (w_rd_acc) begin
            r_rdata <= w_rd_data;
            if (host.host_addr == 4'd0) begin
                r_snap_tos <= i_top_of_stack;
                r_snap_sos <= i_second_of_stack;
                r_snap_cnt <= i_inst_count;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_getin      <= 16'h0000;
            o_getin2     <= 16'h0000;
            r_stage_lo   <= 8'h00;
            r_stage2_lo  <= 8'h00;
            o_proc_reset <= RESET_HOLD;
        end else if (w_wr_acc) begin
            case (host.host_addr)
                4'd0: r_stage_lo   <= host.host_wdata;
                4'd1: o_getin      <= {host.host_wdata, r_stage_lo};
                4'd2: r_stage2_lo  <= host.host_wdata;
                4'd3: o_getin2     <= {host.host_wdata, r_stage2_lo};
                4'd4: o_proc_reset <= host.host_wdata[0];
                default: ;
            endcase
        end
    end

    assign w_clear_halt = w_wr_acc && (host.host_addr == 4'd4) && host.host_wdata[1];
    assign w_stalled    = !o_proc_reset && (i_inst_count == r_prev_cnt);

    // Clear takes priority over a threshold hit in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev_cnt <= 32'h0;
            r_halt_cnt <= '0;
            o_halted   <= 1'b0;
        end else begin
            r_prev_cnt <= i_inst_count;
            if (w_clear_halt) begin
                r_halt_cnt <= '0;
                o_halted   <= 1'b0;
            end else if (!w_stalled) begin
                r_halt_cnt <= '0;
            end else if (r_halt_cnt == HALT_W'(HALT_CYCLES - 1)) begin
                o_halted   <= 1'b1;
            end else begin
                r_halt_cnt <= r_halt_cnt + 1'b1;
            end
        end
    end
endmodule
